// File: rtl/power_pipe_pkg.sv
// Shared definitions for the power_pipe block: overflow mode constants,
// exponent-select width and the exponent clamp helper.
package power_pipe_pkg;

    // Overflow handling modes for the SATURATE parameter.
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Width of the exponent select needed to encode 0..num_stages.
    function automatic int exp_width(input int num_stages);
        return $clog2(num_stages + 1);
    endfunction

    // Requested squarings beyond the pipe depth collapse to the full depth.
    function automatic int clamp_exp(input int k, input int num_stages);
        return (k > num_stages) ? num_stages : k;
    endfunction

endpackage

// File: rtl/power_square_stage.sv
// One registered squaring stage. The stage squares its input when the
// transaction's k says this stage is still inside the requested squaring
// count, tracks sticky overflow, and loads only when its advance enable is set.
module power_square_stage
    import power_pipe_pkg::*;
#(
    parameter int OUT_WIDTH = 64,
    parameter int SATURATE  = MODE_SAT,
    parameter int STAGE_IDX = 0,
    parameter int EXP_W     = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 adv,
    input  logic                 in_valid,
    input  logic [OUT_WIDTH-1:0] in_value,
    input  logic [EXP_W-1:0]     in_k,
    input  logic                 in_ovf,
    output logic                 valid,
    output logic [OUT_WIDTH-1:0] value,
    output logic [EXP_W-1:0]     k,
    output logic                 ovf
);

    localparam int PW = 2 * OUT_WIDTH;

    logic [PW-1:0]        product;
    logic [OUT_WIDTH-1:0] value_next;
    logic                 ovf_next;

    // Conditional full-width square with sticky overflow and saturate/wrap select.
    always_comb begin
        product    = PW'(in_value) * PW'(in_value);
        value_next = in_value;
        ovf_next   = in_ovf;
        if (int'(in_k) > STAGE_IDX) begin
            ovf_next = in_ovf || (product[PW-1:OUT_WIDTH] != '0);
            if (ovf_next && (SATURATE == MODE_SAT)) begin
                value_next = '1;
            end else begin
                value_next = product[OUT_WIDTH-1:0];
            end
        end
    end

    // Stage register: cleared by reset, otherwise loads whenever the stage advances.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid <= 1'b0;
            value <= '0;
            k     <= '0;
            ovf   <= 1'b0;
        end else if (adv) begin
            valid <= in_valid;
            value <= value_next;
            k     <= in_k;
            ovf   <= ovf_next;
        end
    end

endmodule

// File: rtl/power_pipe.sv
// Pipelined power unit: y = x^(2^k), k chosen per transaction and clamped to
// the pipe depth. Fixed latency of NUM_STAGES cycles regardless of k.
//
// Handshake: an input transfer happens on a rising edge with i_valid && i_ready,
// an output transfer on a rising edge with o_valid && o_ready. A stage advances
// when it is empty or the stage after it advances, so bubbles collapse and a
// full pipe still accepts an input in the same cycle the consumer takes an
// output. While o_valid && !o_ready the output registers do not load, which
// keeps o_valid, o_data and o_ovf stable. Outputs come straight from the last
// stage registers; there is no combinational input-to-output path.
module power_pipe
    import power_pipe_pkg::*;
#(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 64,
    parameter int NUM_STAGES = 3,
    parameter int SATURATE   = MODE_SAT,
    parameter int EXP_W      = exp_width(NUM_STAGES)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [IN_WIDTH-1:0]  i_data,
    input  logic [EXP_W-1:0]     i_exp_sel,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic                 o_ovf
);

    logic [NUM_STAGES-1:0] adv;
    logic [NUM_STAGES-1:0] stage_valid;
    logic [NUM_STAGES-1:0] stage_ovf;
    logic [OUT_WIDTH-1:0]  stage_value [NUM_STAGES];
    logic [EXP_W-1:0]      stage_k     [NUM_STAGES];

    logic [NUM_STAGES-1:0] feed_valid;
    logic [NUM_STAGES-1:0] feed_ovf;
    logic [OUT_WIDTH-1:0]  feed_value  [NUM_STAGES];
    logic [EXP_W-1:0]      feed_k      [NUM_STAGES];

    logic [EXP_W-1:0]      k_clamped;
    logic                  unused_k;

    assign k_clamped = EXP_W'(clamp_exp(int'(i_exp_sel), NUM_STAGES));

    // Advance chain, walked from the output back towards the input.
    always_comb begin
        logic chain;
        adv   = '0;
        chain = !stage_valid[NUM_STAGES-1] || o_ready;
        adv[NUM_STAGES-1] = chain;
        for (int s = NUM_STAGES - 2; s >= 0; s--) begin
            chain  = !stage_valid[s] || chain;
            adv[s] = chain;
        end
    end

    generate
        for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
            if (s == 0) begin : g_head
                assign feed_valid[s] = i_valid;
                assign feed_value[s] = OUT_WIDTH'(i_data);
                assign feed_k[s]     = k_clamped;
                assign feed_ovf[s]   = 1'b0;
            end else begin : g_body
                assign feed_valid[s] = stage_valid[s-1];
                assign feed_value[s] = stage_value[s-1];
                assign feed_k[s]     = stage_k[s-1];
                assign feed_ovf[s]   = stage_ovf[s-1];
            end

            power_square_stage #(
                .OUT_WIDTH (OUT_WIDTH),
                .SATURATE  (SATURATE),
                .STAGE_IDX (s),
                .EXP_W     (EXP_W)
            ) u_stage (
                .clk      (clk),
                .reset_n  (reset_n),
                .adv      (adv[s]),
                .in_valid (feed_valid[s]),
                .in_value (feed_value[s]),
                .in_k     (feed_k[s]),
                .in_ovf   (feed_ovf[s]),
                .valid    (stage_valid[s]),
                .value    (stage_value[s]),
                .k        (stage_k[s]),
                .ovf      (stage_ovf[s])
            );
        end
    endgenerate

    // The last stage's k has no consumer.
    assign unused_k = ^stage_k[NUM_STAGES-1];

    assign i_ready = adv[0] && reset_n;
    assign o_valid = stage_valid[NUM_STAGES-1];
    assign o_data  = stage_value[NUM_STAGES-1];
    assign o_ovf   = stage_ovf[NUM_STAGES-1];

endmodule

// File: tb/tb_power_pipe.sv
// Bench for power_pipe: default instance (saturate, 3 stages) under directed
// and randomized traffic with a scoreboard, plus a wrap-mode instance and a
// 4-stage instance for the overflow-wrap and exponent-clamp cases.
module tb_power_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        a_i_valid = 0, a_i_ready, a_o_valid, a_o_ready = 1, a_o_ovf;
    logic [31:0] a_i_data = 0;
    logic [1:0]  a_i_exp_sel = 0;
    logic [63:0] a_o_data;

    logic        b_i_valid = 0, b_i_ready, b_o_valid, b_o_ready = 1, b_o_ovf;
    logic [31:0] b_i_data = 0;
    logic [1:0]  b_i_exp_sel = 0;
    logic [63:0] b_o_data;

    logic        c_i_valid = 0, c_i_ready, c_o_valid, c_o_ready = 1, c_o_ovf;
    logic [31:0] c_i_data = 0;
    logic [2:0]  c_i_exp_sel = 0;
    logic [63:0] c_o_data;

    power_pipe dut_a (
        .clk(clk), .reset_n(reset_n),
        .i_valid(a_i_valid), .i_ready(a_i_ready), .i_data(a_i_data), .i_exp_sel(a_i_exp_sel),
        .o_valid(a_o_valid), .o_ready(a_o_ready), .o_data(a_o_data), .o_ovf(a_o_ovf)
    );

    power_pipe #(.SATURATE(0)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .i_valid(b_i_valid), .i_ready(b_i_ready), .i_data(b_i_data), .i_exp_sel(b_i_exp_sel),
        .o_valid(b_o_valid), .o_ready(b_o_ready), .o_data(b_o_data), .o_ovf(b_o_ovf)
    );

    power_pipe #(.NUM_STAGES(4)) dut_c (
        .clk(clk), .reset_n(reset_n),
        .i_valid(c_i_valid), .i_ready(c_i_ready), .i_data(c_i_data), .i_exp_sel(c_i_exp_sel),
        .o_valid(c_o_valid), .o_ready(c_o_ready), .o_data(c_o_data), .o_ovf(c_o_ovf)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: true value of x^(2^k) with k clamped; anything >= 2^64 is an
    // overflow, reported as all-ones (saturate) or the value modulo 2^64 (wrap).
    function automatic logic [64:0] model_pow(input logic [63:0] x, input int k,
                                              input int n_stages, input bit sat);
        logic [127:0] exact;
        logic [63:0]  modv;
        bit           big;
        int           kk;
        kk    = (k > n_stages) ? n_stages : k;
        exact = {64'd0, x};
        modv  = x;
        big   = 1'b0;
        for (int i = 0; i < kk; i++) begin
            modv = modv * modv;
            if (!big) begin
                exact = exact * exact;
                if (exact[127:64] != 0) big = 1'b1;
            end
        end
        if (big) return {1'b1, sat ? 64'hFFFF_FFFF_FFFF_FFFF : modv};
        return {1'b0, modv};
    endfunction

    // ---------------- scoreboard for dut_a ----------------
    logic [64:0] exp_q[$];
    int          a_acc_cnt = 0;
    bit          hold_pend = 0;
    logic [64:0] hold_val;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            hold_pend = 0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", {64'd0, a_o_valid}, 65'd1);
                check("hold_data", {a_o_ovf, a_o_data}, hold_val);
            end
            if (a_o_valid && a_o_ready) begin
                check("sb_has_entry", {64'd0, exp_q.size() != 0}, 65'd1);
                if (exp_q.size() != 0) check("sb_out", {a_o_ovf, a_o_data}, exp_q.pop_front());
            end
            hold_pend = a_o_valid && !a_o_ready;
            hold_val  = {a_o_ovf, a_o_data};
            if (a_i_valid && a_i_ready) begin
                exp_q.push_back(model_pow({32'd0, a_i_data}, int'(a_i_exp_sel), 3, 1'b1));
                a_acc_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_in(input int which, input logic v, input logic [31:0] x, input int k);
        case (which)
            0: begin a_i_valid = v; a_i_data = x; a_i_exp_sel = 2'(k); end
            1: begin b_i_valid = v; b_i_data = x; b_i_exp_sel = 2'(k); end
            default: begin c_i_valid = v; c_i_data = x; c_i_exp_sel = 3'(k); end
        endcase
    endtask

    function automatic logic in_rdy(input int which);
        case (which)
            0: return a_i_ready;
            1: return b_i_ready;
            default: return c_i_ready;
        endcase
    endfunction

    function automatic logic out_xfer(input int which);
        case (which)
            0: return a_o_valid && a_o_ready;
            1: return b_o_valid && b_o_ready;
            default: return c_o_valid && c_o_ready;
        endcase
    endfunction

    function automatic logic [64:0] out_val(input int which);
        case (which)
            0: return {a_o_ovf, a_o_data};
            1: return {b_o_ovf, b_o_data};
            default: return {c_o_ovf, c_o_data};
        endcase
    endfunction

    // Present one transaction; returns at posedge+1 after it was taken.
    task automatic send(input int which, input logic [31:0] x, input int k, output int tries);
        bit accepted;
        accepted = 0;
        tries = 0;
        set_in(which, 1'b1, x, k);
        while (!accepted && tries < 200) begin
            @(negedge clk);
            accepted = in_rdy(which) && reset_n;
            @(posedge clk); #1;
            tries++;
        end
        set_in(which, 1'b0, x, k);
        check("send_accept", {64'd0, accepted}, 65'd1);
    endtask

    // Wait for the next output transfer; n counts negedges waited.
    task automatic wait_out(input int which, output logic [64:0] got, output int n);
        bit seen;
        seen = 0;
        n = 0;
        got = '0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            seen = out_xfer(which);
            if (seen) got = out_val(which);
        end
        check("out_seen", {64'd0, seen}, 65'd1);
        @(posedge clk); #1;
    endtask

    task automatic drain_a();
        int n;
        n = 0;
        a_o_ready = 1;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 65'(exp_q.size()), 65'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    bit done = 0;

    initial begin
        logic [64:0] got;
        int          n, tries, base, vcnt;
        logic [31:0] x;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_o_valid", {64'd0, a_o_valid}, 65'd0);
        check("rst_o_data", {1'b0, a_o_data}, 65'd0);
        check("rst_o_ovf", {64'd0, a_o_ovf}, 65'd0);
        check("rst_i_ready", {64'd0, a_i_ready}, 65'd0);
        @(posedge clk); #1;
        reset_n = 1;
        @(negedge clk);
        check("rel_i_ready", {64'd0, a_i_ready}, 65'd1);
        @(posedge clk); #1;

        // Latency and basic values
        send(0, 32'd3, 3, tries);
        wait_out(0, got, n);
        check("lat_3", 65'(n), 65'd3);
        check("x3_k3", got, {1'b0, 64'd6561});
        send(0, 32'd2, 0, tries);
        wait_out(0, got, n);
        check("x2_k0", got, {1'b0, 64'd2});

        // Overflow, saturate mode
        send(0, 32'd65536, 2, tries);
        wait_out(0, got, n);
        check("sat_ovf", got, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        send(0, 32'd65535, 2, tries);
        wait_out(0, got, n);
        check("sat_noovf", got, {1'b0, 64'hFFFC_0005_FFFC_0001});
        send(0, 32'd0, 3, tries);
        wait_out(0, got, n);
        check("x0_k3", got, 65'd0);
        send(0, 32'd1, 3, tries);
        wait_out(0, got, n);
        check("x1_k3", got, 65'd1);

        // Back-to-back stream
        fork
            begin
                for (int i = 1; i <= 5; i++) begin
                    send(0, 32'(i), 1, tries);
                    check("b2b_ready", 65'(tries), 65'd1);
                end
            end
            begin
                vcnt = 0;
                do begin
                    @(negedge clk);
                    vcnt++;
                end while (!a_o_valid && vcnt < 20);
                check("b2b_first", {64'd0, a_o_valid}, 65'd1);
                repeat (4) begin
                    @(negedge clk);
                    check("b2b_consec", {64'd0, a_o_valid}, 65'd1);
                end
            end
        join
        drain_a();

        // Backpressure: o_ready low for 6 cycles
        base = a_acc_cnt;
        fork
            begin
                for (int i = 1; i <= 5; i++) send(0, 32'(i), 1, tries);
            end
            begin
                a_o_ready = 0;
                repeat (5) @(posedge clk);
                @(negedge clk);
                check("bp_held", 65'(a_acc_cnt - base), 65'd3);
                check("bp_i_ready", {64'd0, a_i_ready}, 65'd0);
                check("bp_o_data", {a_o_ovf, a_o_data}, 65'd1);
                @(posedge clk); #1;
                a_o_ready = 1;
            end
        join
        drain_a();
        check("bp_total", 65'(a_acc_cnt - base), 65'd5);

        // Randomized traffic with random backpressure
        done = 0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    case ($urandom_range(0, 3))
                        0: x = $urandom_range(0, 20);
                        1: x = $urandom_range(240, 270);
                        2: x = $urandom_range(65530, 65541);
                        default: x = $urandom();
                    endcase
                    send(0, x, $urandom_range(0, 3), tries);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    a_o_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain_a();

        // Wrap mode
        send(1, 32'd65536, 2, tries);
        wait_out(1, got, n);
        check("wrap_ovf", got, {1'b1, 64'd0});
        send(1, 32'd65535, 2, tries);
        wait_out(1, got, n);
        check("wrap_noovf", got, {1'b0, 64'hFFFC_0005_FFFC_0001});
        send(1, 32'd70000, 3, tries);
        wait_out(1, got, n);
        check("wrap_rand", got, model_pow(64'd70000, 3, 3, 1'b0));

        // Exponent clamp on the 4-stage instance
        send(2, 32'd2, 7, tries);
        wait_out(2, got, n);
        check("clamp_lat", 65'(n), 65'd4);
        check("clamp_k7", got, {1'b0, 64'd65536});
        send(2, 32'd3, 5, tries);
        wait_out(2, got, n);
        check("clamp_k5", got, {1'b0, 64'd43046721});
        send(2, 32'd256, 4, tries);
        wait_out(2, got, n);
        check("n4_sat", got, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});

        // Reset with two transactions in flight
        a_o_ready = 1;
        send(0, 32'd5, 1, tries);
        send(0, 32'd6, 1, tries);
        reset_n = 0;
        @(negedge clk);
        check("mid_rst_i_ready", {64'd0, a_i_ready}, 65'd0);
        @(posedge clk); #1;
        reset_n = 1;
        @(negedge clk);
        check("mid_rst_o_valid", {64'd0, a_o_valid}, 65'd0);
        check("mid_rst_o_data", {1'b0, a_o_data}, 65'd0);
        check("mid_rst_o_ovf", {64'd0, a_o_ovf}, 65'd0);
        check("mid_rel_i_ready", {64'd0, a_i_ready}, 65'd1);
        vcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (a_o_valid) vcnt++;
        end
        check("mid_rst_no_out", 65'(vcnt), 65'd0);
        check("final_q_empty", 65'(exp_q.size()), 65'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
